// File: rtl/cpu0_pkg.sv
// Shared CPU0 I/O definitions: operand size codes, console I/O address map and
// the UART transmitter state encoding.
package cpu0_pkg;

  // Operand size codes as driven on m_size
  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] INT16 = 2'b01;
  localparam logic [1:0] INT24 = 2'b10;
  localparam logic [1:0] INT32 = 2'b11;

  // Console I/O base and register offsets
  localparam logic [31:0] IOADDR     = 32'h0001_0000;
  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Number of bytes carried by a write of the given operand size (1..4)
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    return {1'b0, size} + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: synchronous push/pop, full/empty/count.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; push+pop together keeps the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu0_uart_tx.sv
// CPU0 console UART transmitter: memory-mapped DATA/STATUS/CTRL registers, a
// 4-byte staging register that feeds a byte FIFO, and an 8N1 serial FSM.
// Optional TX-drained interrupt enabled by defining UART_TX_IRQ_EN.
module cpu0_uart_tx
  import cpu0_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE         = IOADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] AddrData   = BASE + OFS_DATA;
  localparam logic [31:0] AddrStatus = BASE + OFS_STATUS;
  localparam logic [31:0] AddrCtrl   = BASE + OFS_CTRL;

  logic             hit_data, hit_status, hit_ctrl;
  logic             wr_data_d, wr_data_q, wr_first;
  logic             rd_stat_d, rd_stat_q, rd_stat_first;
  logic [31:0]      stage_data_q, stage_data_d;
  logic [2:0]       stage_len_q, stage_len_d;
  logic             push, pop, ovf_set;
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CntW-1:0]  fifo_count;
  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic             baud_done;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             busy;
  logic [31:0]      rdata;
  logic             rd_sel;

  assign hit_data   = en & (abus == AddrData);
  assign hit_status = en & (abus == AddrStatus);
  assign hit_ctrl   = en & (abus == AddrCtrl);

  // A held strobe is accepted only on its first cycle
  assign wr_data_d     = hit_data & ~rw;
  assign wr_first      = wr_data_d & ~wr_data_q;
  assign rd_stat_d     = hit_status & rw;
  assign rd_stat_first = rd_stat_d & ~rd_stat_q;

  // Staging drain (stops at a 00 byte) and write capture; overflow detection
  always_comb begin
    stage_data_d = stage_data_q;
    stage_len_d  = stage_len_q;
    push         = 1'b0;
    ovf_set      = 1'b0;
    if (stage_len_q != 3'd0) begin
      if (stage_data_q[7:0] == 8'h00) begin
        stage_len_d = 3'd0;
      end else if (fifo_full) begin
        ovf_set     = 1'b1;
        stage_len_d = 3'd0;
      end else begin
        push         = 1'b1;
        stage_data_d = {8'h00, stage_data_q[31:8]};
        stage_len_d  = stage_len_q - 3'd1;
      end
    end
    if (wr_first) begin
      if (stage_len_q != 3'd0) begin
        ovf_set = 1'b1;
      end else begin
        stage_data_d = dbus_in;
        stage_len_d  = size_to_len(m_size);
      end
    end
  end

  // Sticky overflow: a new overflow wins over the clear-on-read
  always_comb begin
    ovf_d = ovf_q;
    if (rd_stat_first) ovf_d = 1'b0;
    if (ovf_set)       ovf_d = 1'b1;
  end

  // Bus strobe history, staging and overflow registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_data_q    <= 1'b0;
      rd_stat_q    <= 1'b0;
      stage_data_q <= '0;
      stage_len_q  <= 3'd0;
      ovf_q        <= 1'b0;
    end else begin
      wr_data_q    <= wr_data_d;
      rd_stat_q    <= rd_stat_d;
      stage_data_q <= stage_data_d;
      stage_len_q  <= stage_len_d;
      ovf_q        <= ovf_d;
    end
  end

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (stage_data_q[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_done = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  // Transmitter state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Transmitter next state; STOP chains straight into START when data waits
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BaudW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          state_d = StStart;
          shreg_d = fifo_rdata;
        end
      end
      StStart: begin
        if (baud_done) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d  = '0;
          shreg_d = {1'b1, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            state_d = StStart;
            shreg_d = fifo_rdata;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transmitter outputs: serial line and FIFO pop
  always_comb begin
    txd = 1'b1;
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = ~fifo_empty;
      StStart: txd = 1'b0;
      StData:  txd = shreg_q[0];
      StStop:  pop = baud_done & ~fifo_empty;
      default: txd = 1'b1;
    endcase
  end

  assign busy = (state_q != StIdle) | (stage_len_q != 3'd0);

`ifdef UART_TX_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  // Interrupt enable write and registered drained condition
  always_comb begin
    ie_d = ie_q;
    if (hit_ctrl & ~rw) ie_d = dbus_in[0];
    irq_d = ie_q & fifo_empty & (stage_len_q == 3'd0) & (state_q == StIdle);
  end

  // Interrupt registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read data mux; DATA and (without the interrupt option) CTRL read as zero
  always_comb begin
    rdata = 32'h0;
    if (hit_status) begin
      rdata = {21'h0, 7'(fifo_count), ovf_q, busy, fifo_full, fifo_empty};
    end
`ifdef UART_TX_IRQ_EN
    else if (hit_ctrl) begin
      rdata = {31'h0, ie_q};
    end
`endif
  end

  assign rd_sel   = rw & ~reset & (hit_data | hit_status | hit_ctrl);
  assign dbus_out = rd_sel ? rdata : 32'hZZZZZZZZ;

endmodule
